posit_encoder: RTL
==================

Name: posit_encoder

Overview:
- Pipelined posit encoder; the inverse of the posit decode path, which splits a posit into sign, regime run, exponent and fraction.
- Takes a decoded value (sign, regime value k, exponent, fraction, zero/NaR flags) and produces a rounded N-bit posit word.
- Sits at the back end of the posit arithmetic datapath, feeding results back into posit storage.
- Two register stages with valid/ready handshake on both sides.

Parameters:
- N, 8: posit word width.
- ES, 1: exponent field width.
- KW, 4: width of signed regime value k_in (two's complement).
- FW, 8: fraction input width, bits after the hidden 1, MSB-first.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept input.
- sign_in  in  1  sign, 1 = negative.
- k_in  in  KW  signed regime value.
- exp_in  in  ES  exponent field.
- frac_in  in  FW  fraction bits, hidden bit excluded.
- zero_in  in  1  value is exact zero.
- nar_in  in  1  value is NaR.
- out_valid  out  1  posit output valid.
- out_ready  in  1  downstream accepts output.
- posit_out  out  N  encoded posit.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): s1_valid=0, s2_valid=0, out_valid=0, posit_out=0. in_ready is 1 in the first cycle after reset.
- Handshake:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - adv2 = ~s2_valid | out_ready; in_ready = ~s1_valid | adv2 (combinational, no dependence on in_valid).
  - While out_valid & ~out_ready, posit_out and out_valid hold stable.
  - Full throughput: one word per cycle when out_ready=1.
  - Latency: 2 cycles from input transfer to out_valid.
  - No word is dropped or duplicated.
- Stage 1 (registered on input transfer): build the magnitude body (N-1 bits) plus guard and sticky.
  - Regime:
    - k>=0: (k+1) ones then a 0.
    - k<0: (-k) zeros then a 1.
  - Then exp_in MSB-first, then frac_in MSB-first, all truncated to N-1 body bits.
  - guard = first bit dropped. sticky = OR of all later dropped bits.
  - Rounding is round-to-nearest-even: round up iff guard & (sticky | body LSB).
  - Clamping:
    - k_in >= N-2 gives maxpos body (all ones).
    - k_in <= -(N-1) gives minpos body (0..01).
    - A rounding carry that would produce all-zero or overflow past maxpos saturates to maxpos.
    - Nonzero, non-NaR inputs never round to 0 or to NaR.
- Stage 2: word = {0, body}; if sign_in=1, word is replaced by its two's complement.
  - zero_in=1 gives 0 (sign ignored).
  - nar_in=1 gives 1 followed by N-1 zeros; nar_in takes priority over zero_in.
- Simultaneous in/out transfer when both stages are full: stage 2 takes stage 1 and stage 1 takes the new input in the same edge.
- Reset mid-operation: in-flight words are discarded and out_valid falls next cycle.

Test Plan:
- N=8, ES=1, out_ready=1:
  - k=0, e=0, frac=0x00, sign 0 -> posit_out 0x40 two cycles later.
  - Same with sign=1 -> 0xC0.
  - k=-1, e=0, frac=0 -> 0x20.
- Rounding:
  - k=0, e=0, frac=0x08 (tie, LSB 0) -> 0x40.
  - frac=0x18 (tie, LSB 1) -> 0x42.
  - frac=0x09 (above half) -> 0x41.
- Saturation:
  - k=7 -> 0x7F.
  - k=-8 -> 0x01.
  - k=5, e=1, frac=0x80 (sticky) -> 0x7F.
  - k=-6, sign=1 -> 0xFF.
- Specials:
  - zero_in=1, sign=1 -> 0x00.
  - nar_in=1 and zero_in=1 -> 0x80.
- Backpressure:
  - Stream 5 words, hold out_ready=0 for 4 cycles mid-stream.
  - in_ready drops once both stages are full; posit_out stays stable while stalled.
  - All 5 outputs arrive in order with no loss or duplication.
- Reset with both stages full -> out_valid=0 and in_ready=1 on the next cycle; no stale word is emitted.

Source files
------------

// File: rtl/posit_encoder_if.sv
// Handshake and data bundle between a posit decode/arith producer and the
// posit encoder. The master drives the decoded value and the output ready;
// the slave (encoder) drives in_ready and the encoded result.
interface posit_encoder_if #(
    parameter int N  = 8,
    parameter int ES = 1,
    parameter int KW = 4,
    parameter int FW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          sign_in;
    logic [KW-1:0] k_in;
    logic [ES-1:0] exp_in;
    logic [FW-1:0] frac_in;
    logic          zero_in;
    logic          nar_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  posit_out;

    modport master (
        output in_valid, sign_in, k_in, exp_in, frac_in, zero_in, nar_in, out_ready,
        input  in_ready, out_valid, posit_out
    );

    modport slave (
        input  in_valid, sign_in, k_in, exp_in, frac_in, zero_in, nar_in, out_ready,
        output in_ready, out_valid, posit_out
    );
endinterface

// File: rtl/posit_encoder.sv
// Two-stage pipelined posit encoder. Stage 1 lays out regime, exponent and
// fraction into an N-1 bit magnitude body and keeps guard/sticky for the
// dropped tail; stage 2 rounds to nearest-even, saturates, applies the sign
// and resolves zero/NaR.
module posit_encoder #(
    parameter int N  = 8,
    parameter int ES = 1,
    parameter int KW = 4,
    parameter int FW = 8
) (
    input logic             clk,
    input logic             rst,
    posit_encoder_if.slave  bus
);
    localparam int SW  = N + ES + FW;
    localparam int KW1 = KW + 1;
    localparam logic signed [KW:0] KMAX = KW1'(N - 2);
    localparam logic signed [KW:0] KMIN = KW1'(-(N - 1));
    localparam logic [SW-1:0] ALL1 = '1;
    localparam logic [SW-1:0] TOP1 = {1'b1, {(SW-1){1'b0}}};

    logic adv2;
    logic s1_valid, s2_valid;

    logic [N-2:0] s1_body;
    logic         s1_guard, s1_sticky, s1_sign, s1_zero, s1_nar;
    logic [N-1:0] s2_word;

    logic signed [KW:0] kx;
    logic         kneg;
    logic [KW:0]  ka, rl;
    logic [SW-1:0] rvec, tvec, vec;
    logic [N-2:0] body_c;
    logic         guard_c, sticky_c;

    logic         rnd;
    logic [N-1:0] sum;
    logic [N-2:0] rbody;
    logic [N-1:0] word_c;

    assign adv2          = ~s2_valid | bus.out_ready;
    assign bus.in_ready  = ~s1_valid | adv2;
    assign bus.out_valid = s2_valid;
    assign bus.posit_out = s2_word;

    // Stage-1 layout: regime run (ka bits) plus terminator, then exp/frac
    // shifted in behind it; clamp out-of-range regimes to maxpos/minpos.
    always_comb begin
        kx   = {bus.k_in[KW-1], bus.k_in};
        kneg = bus.k_in[KW-1];
        ka   = kneg ? -kx : kx + KW1'(1);
        rl   = ka + KW1'(1);
        rvec = kneg ? (TOP1 >> ka) : ~(ALL1 >> ka);
        tvec = {bus.exp_in, bus.frac_in, {N{1'b0}}} >> rl;
        vec  = rvec | tvec;
        body_c   = vec[SW-1 -: N-1];
        guard_c  = vec[SW-N];
        sticky_c = |vec[SW-N-1:0];
        if (kx >= KMAX) begin
            body_c   = '1;
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end else if (kx <= KMIN) begin
            body_c   = (N-1)'(1);
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end
    end

    // Stage-1 register: capture body/guard/sticky and flags on input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_body   <= body_c;
                s1_guard  <= guard_c;
                s1_sticky <= sticky_c;
                s1_sign   <= bus.sign_in;
                s1_zero   <= bus.zero_in;
                s1_nar    <= bus.nar_in;
            end
        end
    end

    // Stage-2 datapath: round-nearest-even with saturation, sign, specials.
    always_comb begin
        rnd   = s1_guard & (s1_sticky | s1_body[0]);
        sum   = {1'b0, s1_body} + N'(rnd);
        rbody = sum[N-1] ? '1 : sum[N-2:0];
        if (rbody == '0)
            rbody = (N-1)'(1);
        word_c = s1_sign ? -{1'b0, rbody} : {1'b0, rbody};
        if (s1_nar)
            word_c = {1'b1, {(N-1){1'b0}}};
        else if (s1_zero)
            word_c = '0;
    end

    // Stage-2 register: advance when empty or downstream accepts; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_word <= word_c;
        end
    end
endmodule
